// File: rtl/fp_widen_unpacker.sv
// fp_widen_unpacker: unpacks 64-bit words holding 4 halves, 2 singles or
// 1 double (element 0 in the LSBs) and emits one IEEE-754 double per
// output handshake through an elastic pipeline.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mode[1:0]                     0 half, 1 single, 2/3 double (sampled on accept)
//   in_valid/in_ready/in_data     input word handshake and payload
//   in_cnt[2:0], in_last          valid element count (0 = full), frame end
//   out_valid/out_ready/out_data  converted element handshake and payload
//   out_idx, out_last             element index in its word, frame-last marker
//   out_nan, out_inf              classification of out_data
//   conv_count                    output handshakes since reset (wraps)
module fp_widen_unpacker #(
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [2:0]       in_cnt,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             out_nan,
  output logic             out_inf,
  output logic [CNT_W-1:0] conv_count
);

  localparam int unsigned DEPTH = PIPE_DEPTH;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  idx;
    logic        last;
  } elem_t;

  // Half -> double, exact for every encoding.
  function automatic logic [63:0] half_to_double(input logic [15:0] h);
    logic        s;
    logic [4:0]  e;
    logic [9:0]  m;
    logic [3:0]  p;
    logic [61:0] sh;
    logic [63:0] r;
    s  = h[15];
    e  = h[14:10];
    m  = h[9:0];
    p  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (m[i]) p = 4'(i);
    end
    // Shifting by the leading-one position drops the hidden bit out of the
    // 52-bit window and left-aligns the remaining fraction bits.
    sh = {m, 52'b0} >> p;
    if (e == 5'd0 && m == 10'd0)      r = {s, 63'b0};
    else if (e == 5'd0)               r = {s, 11'd999 + 11'(p), sh[51:0]};
    else if (e == 5'd31 && m == '0)   r = {s, 11'h7FF, 52'b0};
    else if (e == 5'd31)              r = {s, 11'h7FF, 1'b1, m[8:0], 42'b0};
    else                              r = {s, 11'(e) + 11'd1008, m, 42'b0};
    return r;
  endfunction

  // Single -> double, exact for every encoding.
  function automatic logic [63:0] single_to_double(input logic [31:0] f);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [4:0]  p;
    logic [74:0] sh;
    logic [63:0] r;
    s  = f[31];
    e  = f[30:23];
    m  = f[22:0];
    p  = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (m[i]) p = 5'(i);
    end
    sh = {m, 52'b0} >> p;
    if (e == 8'd0 && m == 23'd0)      r = {s, 63'b0};
    else if (e == 8'd0)               r = {s, 11'd874 + 11'(p), sh[51:0]};
    else if (e == 8'd255 && m == '0)  r = {s, 11'h7FF, 52'b0};
    else if (e == 8'd255)             r = {s, 11'h7FF, 1'b1, m[21:0], 29'b0};
    else                              r = {s, 11'(e) + 11'd896, m, 29'b0};
    return r;
  endfunction

  logic             hold_valid;
  logic [63:0]      hold_data;
  logic [1:0]       hold_fmt;
  logic [2:0]       hold_n;
  logic             hold_last;
  logic [1:0]       hold_idx;

  logic [DEPTH-1:0] stage_valid;
  elem_t            stage_elem [DEPTH];
  logic [DEPTH-1:0] stage_rdy;

  logic             out_rdy;
  logic             issue;
  logic             final_elem;
  logic             final_issue;
  logic             accept;
  logic [2:0]       elem_per_word;
  logic [2:0]       in_n;
  logic [63:0]      half_word;
  logic [63:0]      single_word;
  elem_t            issue_elem;
  logic [63:0]      tail_data;

  // Backpressure chain: a stage accepts when empty or when it is draining.
  always_comb begin
    stage_rdy = '0;
    out_rdy   = !out_valid || out_ready;
    stage_rdy[DEPTH-1] = !stage_valid[DEPTH-1] || out_rdy;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      stage_rdy[i] = !stage_valid[i] || stage_rdy[i+1];
    end
  end

  // Issue control; in_ready opens on the final issue so words stream gaplessly.
  always_comb begin
    issue       = hold_valid && stage_rdy[0];
    final_elem  = (3'(hold_idx) + 3'd1) == hold_n;
    final_issue = issue && final_elem;
    in_ready    = !rst && (!hold_valid || final_issue);
    accept      = in_valid && in_ready;
  end

  // Element count of an incoming word.
  always_comb begin
    case (mode)
      2'd0:    elem_per_word = 3'd4;
      2'd1:    elem_per_word = 3'd2;
      default: elem_per_word = 3'd1;
    endcase
    if (in_cnt == 3'd0 || in_cnt > elem_per_word) in_n = elem_per_word;
    else                                          in_n = in_cnt;
  end

  // Select and convert the element at hold_idx.
  always_comb begin
    half_word   = hold_data >> (6'(hold_idx) << 4);
    single_word = hold_data >> (6'(hold_idx[0]) << 5);
    issue_elem  = '0;
    case (hold_fmt)
      2'd0:    issue_elem.data = half_to_double(half_word[15:0]);
      2'd1:    issue_elem.data = single_to_double(single_word[31:0]);
      default: issue_elem.data = hold_data;
    endcase
    issue_elem.idx  = hold_idx;
    issue_elem.last = hold_last && final_elem;
    tail_data       = stage_elem[DEPTH-1].data;
  end

  // Holding register, pipeline stages, output register and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      hold_fmt    <= '0;
      hold_n      <= '0;
      hold_last   <= 1'b0;
      hold_idx    <= '0;
      stage_valid <= '0;
      for (int i = 0; i < int'(DEPTH); i++) stage_elem[i] <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      out_last    <= 1'b0;
      out_nan     <= 1'b0;
      out_inf     <= 1'b0;
      conv_count  <= '0;
    end else begin
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= in_data;
        hold_fmt   <= (mode == 2'd3) ? 2'd2 : mode;
        hold_n     <= in_n;
        hold_last  <= in_last;
        hold_idx   <= '0;
      end else if (final_issue) begin
        hold_valid <= 1'b0;
      end else if (issue) begin
        hold_idx   <= hold_idx + 2'd1;
      end

      if (stage_rdy[0]) begin
        stage_valid[0] <= issue;
        if (issue) stage_elem[0] <= issue_elem;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (stage_rdy[i]) begin
          stage_valid[i] <= stage_valid[i-1];
          if (stage_valid[i-1]) stage_elem[i] <= stage_elem[i-1];
        end
      end

      if (out_rdy) begin
        out_valid <= stage_valid[DEPTH-1];
        if (stage_valid[DEPTH-1]) begin
          out_data <= tail_data;
          out_idx  <= stage_elem[DEPTH-1].idx;
          out_last <= stage_elem[DEPTH-1].last;
          out_nan  <= (&tail_data[62:52]) && (|tail_data[51:0]);
          out_inf  <= (&tail_data[62:52]) && !(|tail_data[51:0]);
        end
      end

      if (out_valid && out_ready) conv_count <= conv_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_widen_unpacker.sv
// Directed testbench for fp_widen_unpacker with hand-computed expected
// elements queued in order and checked on every output handshake.
module tb_fp_widen_unpacker;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic [2:0]    in_cnt;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic [1:0]    out_idx;
  logic          out_last;
  logic          out_nan;
  logic          out_inf;
  logic [CW-1:0] conv_count;

  fp_widen_unpacker #(.PIPE_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cnt(in_cnt), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_nan(out_nan), .out_inf(out_inf), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  idx;
    logic        last;
    logic        nan;
    logic        inf;
  } exp_t;

  exp_t exp_q[$];
  int   hs_cyc[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] d, input logic [1:0] i, input logic l,
                          input logic n, input logic f);
    exp_t e;
    e.data = d; e.idx = i; e.last = l; e.nan = n; e.inf = f;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every output handshake must match the next queued element.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("extra_output", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_idx", 64'(out_idx), 64'(e.idx));
        check("out_last", 64'(out_last), 64'(e.last));
        check("out_nan", 64'(out_nan), 64'(e.nan));
        check("out_inf", 64'(out_inf), 64'(e.inf));
      end
    end
  end

  // Present one word and hold it until accepted; returns at posedge+1.
  task automatic send_word(input logic [1:0] m, input logic [63:0] d,
                           input logic [2:0] c, input logic l);
    int waited;
    waited = 0;
    mode = m; in_data = d; in_cnt = c; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int t;
    rst = 1'b1; mode = 2'd0; in_valid = 1'b0; in_data = '0; in_cnt = '0;
    in_last = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_conv_count", 64'(conv_count), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // T1: four halves, latency and back-to-back output
    hs_cyc.delete();
    push_exp(64'h3FF0000000000000, 2'd0, 1'b0, 1'b0, 1'b0);
    push_exp(64'h3E70000000000000, 2'd1, 1'b0, 1'b0, 1'b0);
    push_exp(64'h7FF0000000000000, 2'd2, 1'b0, 1'b0, 1'b1);
    push_exp(64'hC000000000000000, 2'd3, 1'b0, 1'b0, 1'b0);
    send_word(2'd0, 64'hC000_7C00_0001_3C00, 3'd0, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t1_latency", 64'(lat), 64'(DEPTH + 1));
    wait_drain("t1_drain");
    check("t1_count", 64'(hs_cyc.size()), 64'd4);
    if (hs_cyc.size() == 4) check("t1_contiguous", 64'(hs_cyc[3] - hs_cyc[0]), 64'd3);
    check("t1_conv_count", 64'(conv_count), 64'd4);

    // T2: single NaN then 1.0; in_cnt above E clamps to E; live mode ignored
    push_exp(64'h7FF8000020000000, 2'd0, 1'b0, 1'b1, 1'b0);
    push_exp(64'h3FF0000000000000, 2'd1, 1'b1, 1'b0, 1'b0);
    send_word(2'd1, 64'h3F800000_7F800001, 3'd7, 1'b1);
    mode = 2'd0; in_cnt = 3'd1;
    wait_drain("t2_drain");

    // T3: smallest single subnormal; mode 3 is a double bypass
    push_exp(64'h36A0000000000000, 2'd0, 1'b0, 1'b0, 1'b0);
    push_exp(64'h7FF0000000000001, 2'd0, 1'b0, 1'b1, 1'b0);
    send_word(2'd1, 64'h7F800000_00000001, 3'd1, 1'b0);
    send_word(2'd3, 64'h7FF0000000000001, 3'd0, 1'b0);
    wait_drain("t3_drain");

    // T4: partial half word with frame-last, then a double with no gap
    hs_cyc.delete();
    push_exp(64'h3FF0000000000000, 2'd0, 1'b0, 1'b0, 1'b0);
    push_exp(64'h3FE0000000000000, 2'd1, 1'b0, 1'b0, 1'b0);
    push_exp(64'h4000000000000000, 2'd2, 1'b1, 1'b0, 1'b0);
    push_exp(64'h4008000000000000, 2'd0, 1'b0, 1'b0, 1'b0);
    send_word(2'd0, 64'h7C00_4000_3800_3C00, 3'd3, 1'b1);
    send_word(2'd2, 64'h4008000000000000, 3'd0, 1'b0);
    wait_drain("t4_drain");
    check("t4_count", 64'(hs_cyc.size()), 64'd4);
    if (hs_cyc.size() == 4) check("t4_contiguous", 64'(hs_cyc[3] - hs_cyc[0]), 64'd3);

    // T5: downstream stall mid-word
    hs_cyc.delete();
    push_exp(64'h3FF0000000000000, 2'd0, 1'b0, 1'b0, 1'b0);
    push_exp(64'h3FE0000000000000, 2'd1, 1'b0, 1'b0, 1'b0);
    push_exp(64'h4000000000000000, 2'd2, 1'b0, 1'b0, 1'b0);
    push_exp(64'hC000000000000000, 2'd3, 1'b0, 1'b0, 1'b0);
    push_exp(64'h0000000000000000, 2'd0, 1'b0, 1'b0, 1'b0);
    push_exp(64'h8000000000000000, 2'd1, 1'b0, 1'b0, 1'b0);
    push_exp(64'h3F10000000000000, 2'd2, 1'b0, 1'b0, 1'b0);
    push_exp(64'h7FF8000000000000, 2'd3, 1'b0, 1'b1, 1'b0);
    push_exp(64'hBFF0000000000000, 2'd0, 1'b0, 1'b0, 1'b0);
    push_exp(64'h4000000000000000, 2'd1, 1'b1, 1'b0, 1'b0);
    fork
      begin
        send_word(2'd0, 64'hC000_4000_3800_3C00, 3'd0, 1'b0);
        send_word(2'd0, 64'h7E00_0400_8000_0000, 3'd0, 1'b0);
        send_word(2'd1, 64'h40000000_BF800000, 3'd0, 1'b1);
      end
    join_none
    t = 0;
    while (hs_cyc.size() < 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("t5_reach_stall", 64'(hs_cyc.size()), 64'd2);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("t5_stall_valid", 64'(out_valid), 64'd1);
      check("t5_stall_idx", 64'(out_idx), 64'd2);
      check("t5_stall_data", out_data, 64'h4000000000000000);
    end
    check("t5_in_ready_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    wait_drain("t5_drain");
    check("t5_count", 64'(hs_cyc.size()), 64'd10);

    // T6: reset after the second element of a half word
    hs_cyc.delete();
    push_exp(64'h3FF0000000000000, 2'd0, 1'b0, 1'b0, 1'b0);
    push_exp(64'h3FE0000000000000, 2'd1, 1'b0, 1'b0, 1'b0);
    send_word(2'd0, 64'hC000_4000_3800_3C00, 3'd0, 1'b1);
    t = 0;
    while (hs_cyc.size() < 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("t6_reach_reset", 64'(hs_cyc.size()), 64'd2);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_in_ready_rst", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_out_data", out_data, 64'd0);
    check("t6_out_idx", 64'(out_idx), 64'd0);
    check("t6_out_last", 64'(out_last), 64'd0);
    check("t6_out_flags", 64'({out_nan, out_inf}), 64'd0);
    check("t6_conv_count", 64'(conv_count), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_leftovers", 64'(hs_cyc.size()), 64'd2);
    push_exp(64'hBFF0000000000000, 2'd0, 1'b0, 1'b0, 1'b0);
    push_exp(64'h4000000000000000, 2'd1, 1'b1, 1'b0, 1'b0);
    send_word(2'd1, 64'h40000000_BF800000, 3'd0, 1'b1);
    wait_drain("t6_drain");
    check("t6_conv_after", 64'(conv_count), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
